cvp_evaluator: RTL

CVP_EVALUATOR -- requirements
Module: cvp_evaluator

---
 rtl/cvp_evaluator.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cvp_evaluator.sv
// cvp_evaluator: measures exhaled vital capacity, divides it against the predicted CVP and reports percent/error.
// Define CVP_EVAL_FEV1_EN to build the first-second (FEV1) volume capture; otherwise ovFEV1 is tied to 0.
module cvp_evaluator #(
    parameter int MAX_SAMPLES  = 1000,
    parameter int RESTRICT_PCT = 80,
    parameter int FEV1_SAMPLES = 100
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iStart,
    input  logic [9:0]  ivCVP,
    input  logic        iSampleValid,
    input  logic [7:0]  ivFlow,
    input  logic        iStop,
    output logic        oBusy,
    output logic        oDone,
    output logic [15:0] ovVolume,
    output logic [7:0]  ovPercent,
    output logic [15:0] ovFEV1,
    output logic        oRestrictive,
    output logic        oError
);
    localparam int CW = $clog2(MAX_SAMPLES + 1);
    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, DONE} stateT;
    stateT state, stateNext;
    logic [9:0] cvp;
    logic [15:0] acc, accNext, volFinal;
    logic [16:0] accSum;
    logic [CW-1:0] sampleCnt;
    logic sampleErr, hitMax, endMeasure, divLast, finish, errFinal;
    logic [22:0] quo, quoNext;
    logic [9:0] rem;
    logic [10:0] remShift, remNext;
    logic [4:0] divCnt;
    logic [7:0] pctDiv, pctFinal;
    always_comb begin
        accSum = {1'b0, acc} + {9'b0, ivFlow};
        accNext = iSampleValid ? (accSum[16] ? 16'hFFFF : accSum[15:0]) : acc;
        hitMax = iSampleValid && sampleCnt == CW'(MAX_SAMPLES - 1);
        endMeasure = iStop || hitMax;
        remShift = {rem, quo[22]};
        remNext = remShift >= {1'b0, cvp} ? remShift - {1'b0, cvp} : remShift;
        quoNext = {quo[21:0], remShift >= {1'b0, cvp}};
        divLast = divCnt == 5'd22;
        pctDiv = |quoNext[22:8] ? 8'hFF : quoNext[7:0];
        finish = (state == MEASURE && endMeasure && cvp == 10'd0) || (state == DIVIDE && divLast);
        volFinal = state == DIVIDE ? acc : accNext;
        pctFinal = state == DIVIDE ? pctDiv : 8'd0;
        errFinal = state == DIVIDE ? sampleErr : 1'b1;
    end
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = iStart ? MEASURE : IDLE;
            MEASURE: stateNext = endMeasure ? (cvp == 10'd0 ? DONE : DIVIDE) : MEASURE;
            DIVIDE:  stateNext = divLast ? DONE : DIVIDE;
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge iClk)
        if (iReset)
            state <= IDLE;
        else
            state <= stateNext;
    assign oBusy = state == MEASURE || state == DIVIDE;
    assign oDone = state == DONE;
    always_ff @(posedge iClk) begin
        if (iReset) begin
            cvp <= '0;
            acc <= '0;
            sampleCnt <= '0;
            sampleErr <= 1'b0;
            quo <= '0;
            rem <= '0;
            divCnt <= '0;
        end else if (state == IDLE && iStart) begin
            cvp <= ivCVP;
            acc <= '0;
            sampleCnt <= '0;
            sampleErr <= 1'b0;
        end else if (state == MEASURE) begin
            acc <= accNext;
            if (iSampleValid)
                sampleCnt <= sampleCnt + CW'(1);
            if (hitMax && !iStop)
                sampleErr <= 1'b1;
            // The dividend includes a sample arriving together with the end condition
            if (endMeasure) begin
                quo <= 23'(accNext) * 23'd100;
                rem <= '0;
                divCnt <= '0;
            end
        end else if (state == DIVIDE) begin
            quo <= quoNext;
            rem <= remNext[9:0];
            divCnt <= divCnt + 5'd1;
        end
    end
    always_ff @(posedge iClk) begin
        if (iReset) begin
            ovVolume <= '0;
            ovPercent <= '0;
            oRestrictive <= 1'b0;
            oError <= 1'b0;
        end else if (finish) begin
            ovVolume <= volFinal;
            ovPercent <= pctFinal;
            oRestrictive <= pctFinal < 8'(RESTRICT_PCT);
            oError <= errFinal;
        end
    end
`ifdef CVP_EVAL_FEV1_EN
    logic [15:0] fev1;
    logic fev1Hit;
    always_ff @(posedge iClk) begin
        if (iReset || (state == IDLE && iStart)) begin
            fev1 <= '0;
            fev1Hit <= 1'b0;
        end else if (state == MEASURE && iSampleValid && !fev1Hit && sampleCnt == CW'(FEV1_SAMPLES - 1)) begin
            fev1 <= accNext;
            fev1Hit <= 1'b1;
        end
    end
    // A test ending before the window closes reports its whole volume
    always_ff @(posedge iClk)
        if (iReset)
            ovFEV1 <= '0;
        else if (finish)
            ovFEV1 <= fev1Hit ? fev1 : volFinal;
`else
    assign ovFEV1 = 16'd0;
`endif
endmodule
